// File: rtl/adc_poll_avg.sv
// Autonomous XADC DRP poller: periodic single-register reads, 12-bit code extraction,
// and per-block average/min/max with timeout and overrun reporting.
module adc_poll_avg #(
    parameter int unsigned PERIOD_CYCLES  = 2000,
    parameter int unsigned AVG_LOG2       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [6:0]  ch_addr,
    output logic        rd,
    output logic        wr,
    output logic [6:0]  addr,
    output logic [15:0] data_in,
    input  logic        valid,
    input  logic [15:0] data_out,
    output logic        avg_valid,
    output logic [11:0] avg_code,
    output logic [11:0] min_code,
    output logic [11:0] max_code,
    output logic        timeout_err,
    output logic [7:0]  err_count,
    output logic        overrun
);

    localparam int unsigned PW = $clog2(PERIOD_CYCLES);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned AW = 12 + AVG_LOG2;
    localparam int unsigned NW = AVG_LOG2 + 1;
    localparam logic [NW-1:0] N_LAST = NW'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t        state, state_next;
    logic [PW-1:0] per_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          tick;
    logic          accept;
    logic [AW-1:0] acc;
    logic [AW-1:0] acc_next;
    logic [NW-1:0] n;
    logic [11:0]   min_w, max_w;
    logic [11:0]   min_upd, max_upd;
    logic [11:0]   code;
    logic          first;
    logic          unused_bits;

    assign wr          = 1'b0;
    assign data_in     = '0;
    assign code        = data_out[15:4];
    assign unused_bits = ^data_out[3:0];
    assign tick        = enable && (per_cnt == PW'(PERIOD_CYCLES - 1));
    assign first       = (n == '0);
    assign acc_next    = acc + AW'(code);
    assign min_upd     = (first || code < min_w) ? code : min_w;
    assign max_upd     = (first || code > max_w) ? code : max_w;

    always_comb begin
        state_next  = state;
        rd          = 1'b0;
        accept      = 1'b0;
        timeout_err = 1'b0;
        case (state)
            S_IDLE: begin
                if (tick) state_next = S_ISSUE;
            end
            S_ISSUE: begin
                rd         = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (valid) begin
                    accept     = 1'b1;
                    state_next = S_IDLE;
                end else if (tmo_cnt == TW'(TIMEOUT_CYCLES)) begin
                    timeout_err = 1'b1;
                    state_next  = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            per_cnt   <= '0;
            tmo_cnt   <= '0;
            acc       <= '0;
            n         <= '0;
            min_w     <= '0;
            max_w     <= '0;
            addr      <= '0;
            avg_valid <= 1'b0;
            avg_code  <= '0;
            min_code  <= '0;
            max_code  <= '0;
            err_count <= '0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_next;
            avg_valid <= 1'b0;

            if (!enable || tick) per_cnt <= '0;
            else                 per_cnt <= per_cnt + PW'(1);

            if (state != S_WAIT) tmo_cnt <= '0;
            else                  tmo_cnt <= tmo_cnt + TW'(1);

            // A tick during an in-flight read is dropped, not queued.
            if (tick && state != S_IDLE) overrun <= 1'b1;

            if (timeout_err && err_count != 8'hFF) err_count <= err_count + 8'd1;

            if (state == S_IDLE && tick && first) addr <= ch_addr;

            if (accept) begin
                if (n == N_LAST) begin
                    avg_valid <= 1'b1;
                    avg_code  <= 12'(acc_next >> AVG_LOG2);
                    min_code  <= min_upd;
                    max_code  <= max_upd;
                    acc       <= '0;
                    n         <= '0;
                    min_w     <= '0;
                    max_w     <= '0;
                end else begin
                    acc   <= acc_next;
                    n     <= n + NW'(1);
                    min_w <= min_upd;
                    max_w <= max_upd;
                end
            end else if (state == S_IDLE && !enable) begin
                // Partial block is abandoned once polling stops.
                acc   <= '0;
                n     <= '0;
                min_w <= '0;
                max_w <= '0;
                addr  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_adc_poll_avg.sv
// Directed bench for adc_poll_avg: two instances (block of 4 with short timeout,
// and block of 1 with long timeout) driven by an inline DRP responder.
module tb_adc_poll_avg;

    logic        clk = 1'b0;
    logic        rst;

    logic        en_a, valid_a;
    logic [6:0]  ch_a;
    logic [15:0] dout_a;
    logic        rd_a, wr_a, avv_a, tmo_a, ovr_a;
    logic [6:0]  addr_a;
    logic [15:0] din_a;
    logic [11:0] avg_a, min_a, max_a;
    logic [7:0]  err_a;

    logic        en_b, valid_b;
    logic [6:0]  ch_b;
    logic [15:0] dout_b;
    logic        rd_b, wr_b, avv_b, tmo_b, ovr_b;
    logic [6:0]  addr_b;
    logic [15:0] din_b;
    logic [11:0] avg_b, min_b, max_b;
    logic [7:0]  err_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adc_poll_avg #(.PERIOD_CYCLES(8), .AVG_LOG2(2), .TIMEOUT_CYCLES(5)) u_a (
        .clk(clk), .rst(rst), .enable(en_a), .ch_addr(ch_a),
        .rd(rd_a), .wr(wr_a), .addr(addr_a), .data_in(din_a),
        .valid(valid_a), .data_out(dout_a),
        .avg_valid(avv_a), .avg_code(avg_a), .min_code(min_a), .max_code(max_a),
        .timeout_err(tmo_a), .err_count(err_a), .overrun(ovr_a)
    );

    adc_poll_avg #(.PERIOD_CYCLES(8), .AVG_LOG2(0), .TIMEOUT_CYCLES(20)) u_b (
        .clk(clk), .rst(rst), .enable(en_b), .ch_addr(ch_b),
        .rd(rd_b), .wr(wr_b), .addr(addr_b), .data_in(din_b),
        .valid(valid_b), .data_out(dout_b),
        .avg_valid(avv_b), .avg_code(avg_b), .min_code(min_b), .max_code(max_b),
        .timeout_err(tmo_b), .err_count(err_b), .overrun(ovr_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rd(input bit sel, input int limit, input string tag, output int c);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            step();
            seen = sel ? rd_b : rd_a;
        end
        c = cyc;
        check(tag, 32'(seen), 32'd1);
    endtask

    // Responder: valid in the cycle 'delay' cycles after the rd cycle.
    task automatic answer(input bit sel, input int delay, input logic [15:0] d);
        repeat (delay) step();
        if (sel) begin valid_b = 1'b1; dout_b = d; end
        else     begin valid_a = 1'b1; dout_a = d; end
        step();
        valid_a = 1'b0; valid_b = 1'b0;
        dout_a = '0; dout_b = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, c0, c1, e, r, n_av, n_rd, n_to;
        rst = 1'b1;
        en_a = 1'b0; valid_a = 1'b0; ch_a = '0; dout_a = '0;
        en_b = 1'b0; valid_b = 1'b0; ch_b = '0; dout_b = '0;
        repeat (3) step();
        rst = 1'b0;
        check("rst_avg_valid", 32'(avv_a), 32'd0);
        check("rst_avg_code", 32'(avg_a), 32'd0);
        check("rst_min_code", 32'(min_a), 32'd0);
        check("rst_max_code", 32'(max_a), 32'd0);
        check("rst_err_count", 32'(err_a), 32'd0);
        check("rst_overrun", 32'(ovr_a), 32'd0);
        check("rst_rd", 32'(rd_a), 32'd0);
        check("rst_addr", 32'(addr_a), 32'd0);
        check("tied_wr", 32'(wr_a), 32'd0);
        check("tied_data_in", 32'(din_a), 32'd0);

        // Basic block: 0x100,0x200,0x300,0x400 -> avg 0x280
        ch_a = 7'h03; en_a = 1'b1; e = cyc;
        wait_rd(0, 20, "t1_rd0_seen", c0);
        check("t1_first_rd_delay", 32'(c0 - e), 32'd8);
        check("t1_addr", 32'(addr_a), 32'h03);
        answer(0, 3, 16'h1000);
        check("t1_no_early_avg", 32'(avv_a), 32'd0);
        wait_rd(0, 20, "t1_rd1_seen", c1);
        check("t1_rd_spacing", 32'(c1 - c0), 32'd8);
        answer(0, 3, 16'h2000);
        wait_rd(0, 20, "t1_rd2_seen", c);
        answer(0, 3, 16'h3000);
        wait_rd(0, 20, "t1_rd3_seen", c);
        check("t1_rd3_addr", 32'(addr_a), 32'h03);
        answer(0, 3, 16'h4000);
        check("t1_avg_valid", 32'(avv_a), 32'd1);
        check("t1_avg_code", 32'(avg_a), 32'h280);
        check("t1_min_code", 32'(min_a), 32'h100);
        check("t1_max_code", 32'(max_a), 32'h400);
        step();
        check("t1_avg_valid_pulse", 32'(avv_a), 32'd0);
        check("t1_avg_hold", 32'(avg_a), 32'h280);

        // Full-scale block; ch_addr changed after first sample
        for (int k = 0; k < 4; k++) begin
            wait_rd(0, 20, "t2_rd_seen", c);
            if (k == 1) check("t2_addr_held", 32'(addr_a), 32'h03);
            answer(0, 3, 16'hFFF0);
            if (k == 0) ch_a = 7'h10;
        end
        check("t2_avg_valid", 32'(avv_a), 32'd1);
        check("t2_avg_code", 32'(avg_a), 32'hFFF);
        check("t2_min_code", 32'(min_a), 32'hFFF);
        check("t2_max_code", 32'(max_a), 32'hFFF);

        // Partial block abandoned by disabling
        wait_rd(0, 20, "t3_rd0_seen", c);
        check("t3_addr_new", 32'(addr_a), 32'h10);
        answer(0, 3, 16'h0500);
        wait_rd(0, 20, "t3_rd1_seen", c);
        answer(0, 3, 16'h0500);
        en_a = 1'b0;
        n_av = 0; n_rd = 0;
        repeat (30) begin
            step();
            if (avv_a) n_av++;
            if (rd_a) n_rd++;
        end
        check("t3_no_partial_avg", 32'(n_av), 32'd0);
        check("t3_no_rd_disabled", 32'(n_rd), 32'd0);
        check("t3_avg_held", 32'(avg_a), 32'hFFF);
        en_a = 1'b1; e = cyc;
        for (int k = 0; k < 4; k++) begin
            wait_rd(0, 20, "t3_rd_seen", c);
            if (k == 0) check("t3_reenable_delay", 32'(c - e), 32'd8);
            answer(0, 3, 16'h0100);
        end
        check("t3_avg_valid", 32'(avv_a), 32'd1);
        check("t3_avg_code", 32'(avg_a), 32'h010);
        check("t3_min_code", 32'(min_a), 32'h010);
        check("t3_max_code", 32'(max_a), 32'h010);

        // Timeouts: no answer
        wait_rd(0, 20, "t4_rd_seen", c);
        repeat (5) step();
        check("t4_no_tmo_early", 32'(tmo_a), 32'd0);
        step();
        check("t4_tmo_pulse", 32'(tmo_a), 32'd1);
        check("t4_err_before", 32'(err_a), 32'd0);
        step();
        check("t4_tmo_one_cycle", 32'(tmo_a), 32'd0);
        check("t4_err_one", 32'(err_a), 32'd1);
        n_to = 1;
        for (int i = 0; i < 3000 && n_to < 300; i++) begin
            step();
            if (tmo_a) n_to++;
        end
        check("t4_tmo_count", 32'(n_to), 32'd300);
        step();
        check("t4_err_saturated", 32'(err_a), 32'd255);
        check("t4_no_overrun", 32'(ovr_a), 32'd0);

        // Reset in WAIT with valid in the same cycle
        wait_rd(0, 20, "t5_rd_seen", c);
        repeat (2) step();
        rst = 1'b1; valid_a = 1'b1; dout_a = 16'h7770;
        step();
        rst = 1'b0; valid_a = 1'b0; dout_a = '0;
        r = cyc;
        check("t5_avg_valid", 32'(avv_a), 32'd0);
        check("t5_avg_code", 32'(avg_a), 32'd0);
        check("t5_min_code", 32'(min_a), 32'd0);
        check("t5_max_code", 32'(max_a), 32'd0);
        check("t5_err_count", 32'(err_a), 32'd0);
        check("t5_rd", 32'(rd_a), 32'd0);
        check("t5_tmo", 32'(tmo_a), 32'd0);
        for (int k = 0; k < 4; k++) begin
            wait_rd(0, 20, "t5_rd_resume", c);
            if (k == 0) check("t5_resume_delay", 32'(c - r), 32'd8);
            answer(0, 3, 16'h0800);
        end
        check("t5_avg_valid_resume", 32'(avv_a), 32'd1);
        check("t5_avg_code_resume", 32'(avg_a), 32'h080);

        // AVG_LOG2=0 and overrun on instance B
        en_a = 1'b0;
        ch_b = 7'h05; en_b = 1'b1; e = cyc;
        wait_rd(1, 20, "t6_rd_seen", c);
        check("t6_first_rd_delay", 32'(c - e), 32'd8);
        check("t6_addr", 32'(addr_b), 32'h05);
        answer(1, 3, 16'hABC0);
        check("t6_avg_valid", 32'(avv_b), 32'd1);
        check("t6_avg_code", 32'(avg_b), 32'hABC);
        check("t6_min_code", 32'(min_b), 32'hABC);
        check("t6_max_code", 32'(max_b), 32'hABC);

        wait_rd(1, 20, "t7_rd_seen", c0);
        n_rd = 0;
        repeat (7) begin
            step();
            if (rd_b) n_rd++;
        end
        check("t7_overrun_before_tick", 32'(ovr_b), 32'd0);
        step();
        if (rd_b) n_rd++;
        check("t7_overrun_set", 32'(ovr_b), 32'd1);
        repeat (4) begin
            step();
            if (rd_b) n_rd++;
        end
        valid_b = 1'b1; dout_b = 16'h5550;
        step();
        valid_b = 1'b0; dout_b = '0;
        check("t7_avg_valid", 32'(avv_b), 32'd1);
        check("t7_avg_code", 32'(avg_b), 32'h555);
        check("t7_no_rd_in_flight", 32'(n_rd), 32'd0);
        check("t7_no_timeout", 32'(err_b), 32'd0);
        wait_rd(1, 20, "t7_next_rd_seen", c1);
        check("t7_next_rd_delay", 32'(c1 - c0), 32'd16);
        answer(1, 3, 16'h1230);
        check("t7_avg_code_next", 32'(avg_b), 32'h123);
        check("t7_overrun_sticky", 32'(ovr_b), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
